// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared FSM states, word width and access encodings for the data-memory responder
package dmem_responder_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;
  localparam logic [3:0] WR_READ = 4'b0000;
  function automatic int word_w(input int byte_w);
    return 4 * byte_w;
  endfunction
endpackage

// File: rtl/dmem_bram.sv
// dmem_bram: single-port byte-enabled synchronous RAM, write-first, registered read, no reset
module dmem_bram #(
  parameter int BYTE_WIDTH = 8,
  parameter int DEPTH      = 1024,
  parameter int AW         = 10
) (
  input  logic                       clk,
  input  logic                       en_i,
  input  logic [3:0]                 we_i,
  input  logic [AW-1:0]              addr_i,
  input  logic [3:0][BYTE_WIDTH-1:0] wdata_i,
  output logic [3:0][BYTE_WIDTH-1:0] rdata_o
);
  logic [3:0][BYTE_WIDTH-1:0] mem_q [DEPTH];
  logic [3:0][BYTE_WIDTH-1:0] merged_d;
  logic [3:0][BYTE_WIDTH-1:0] rdata_q;
  assign rdata_o = rdata_q;
  // word as it will look after this edge's write, so reads see the new data
  always_comb begin
    for (int i = 0; i < 4; i++) merged_d[i] = we_i[i] ? wdata_i[i] : mem_q[addr_i][i];
  end
  // per-lane write and registered read of the merged word
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < 4; i++) if (we_i[i]) mem_q[addr_i][i] <= wdata_i[i];
      rdata_q <= merged_d;
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated data-memory responder with byte-lane writes and out-of-range errors
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int BYTE_WIDTH  = 8,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1,
  localparam int W          = word_w(BYTE_WIDTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [11:0]  addr,
  input  logic [3:0]   wr_mode,
  input  logic [W-1:0] wdata,
  output logic         rsp_valid,
  output logic [W-1:0] rdata,
  output logic         rsp_err
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [11:0]  addr_q;
  logic [3:0]   mode_q;
  logic [W-1:0] wdata_q;
  logic         rd_ok_q, err_q;
  logic         accept, access, in_range;
  logic [11:0]  acc_addr;
  logic [3:0]   acc_mode;
  logic [W-1:0] acc_wdata, ram_rdata;
  assign req_ready = state_q == S_IDLE;
  assign rsp_valid = state_q == S_RESP;
  assign accept    = req_valid && req_ready;
  // with no wait states the access happens on the accept edge, so use the live request
  assign access    = WAIT_CYCLES == 0 ? accept : (state_q == S_WAIT && cnt_q == 4'd1);
  assign acc_addr  = WAIT_CYCLES == 0 ? addr : addr_q;
  assign acc_mode  = WAIT_CYCLES == 0 ? wr_mode : mode_q;
  assign acc_wdata = WAIT_CYCLES == 0 ? wdata : wdata_q;
  assign in_range  = {1'b0, acc_addr} < 13'(DEPTH);
  assign rdata     = rd_ok_q ? ram_rdata : '0;
  assign rsp_err   = err_q;
  // FSM sequencing and wait-state countdown
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE && accept) begin
      state_d = WAIT_CYCLES == 0 ? S_RESP : S_WAIT;
      cnt_d   = 4'(WAIT_CYCLES);
    end else if (state_q == S_WAIT) begin
      cnt_d   = cnt_q - 4'd1;
      state_d = cnt_q == 4'd1 ? S_RESP : S_WAIT;
    end else if (state_q == S_RESP) begin
      state_d = S_IDLE;
    end
  end
  // state, request capture and response qualifiers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      mode_q  <= '0;
      wdata_q <= '0;
      rd_ok_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= addr;
        mode_q  <= wr_mode;
        wdata_q <= wdata;
      end
      if (access) begin
        rd_ok_q <= in_range && acc_mode == WR_READ;
        err_q   <= !in_range;
      end
    end
  end
  dmem_bram #(
    .BYTE_WIDTH(BYTE_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_bram (
    .clk    (clk),
    .en_i   (access && in_range),
    .we_i   (acc_mode),
    .addr_i (acc_addr[AW-1:0]),
    .wdata_i(acc_wdata),
    .rdata_o(ram_rdata)
  );
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter BYTE_WIDTH, default 8: bits per byte lane; word is 4*BYTE_WIDTH.
REQ-002 Parameter DEPTH, default 1024: number of implemented words, range 1..4096.
REQ-003 Parameter WAIT_CYCLES, default 1: extra access wait states, range 0..15.
REQ-004 Port clk  in  1: single clock; all state updates on rising edge.
REQ-005 Port rst_n  in  1: reset, asynchronous, active-low.
REQ-006 Port req_valid  in  1: request present.
REQ-007 Port req_ready  out  1: responder can accept a request.
REQ-008 Port addr  in  12: word address, as produced by the CPU memory access stage.
REQ-009 Port wr_mode  in  4: byte-lane write enables; 4'b0000 means read.
REQ-010 Port wdata  in  4*BYTE_WIDTH: lane-aligned store data.
REQ-011 Port rsp_valid  out  1: response valid, exactly one cycle per accepted request.
REQ-012 Port rdata  out  4*BYTE_WIDTH: full read word; zero for writes and errors.
REQ-013 Port rsp_err  out  1: addr >= DEPTH; qualified by rsp_valid.

Function
REQ-014 States IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 Accept edge: req_valid && req_ready; addr, wr_mode and wdata SHALL be latched on that edge; inputs are ignored afterwards until the next IDLE.
REQ-016 On the accept edge, WAIT_CYCLES=0 SHALL go directly to RESP and perform the access on that edge. Otherwise the FSM SHALL go to WAIT with the counter loaded to WAIT_CYCLES.
REQ-017 In WAIT the counter SHALL decrement each cycle; the edge on which counter==1 SHALL perform the access and enter RESP.
REQ-018 Access, write (wr_mode != 0, addr < DEPTH): only lanes i with wr_mode[i]=1 are updated from wdata lane i; other lanes are unchanged.
REQ-019 Access, read (wr_mode = 0, addr < DEPTH): rdata SHALL be registered with the stored word.
REQ-020 Access, addr >= DEPTH: no memory write; rdata SHALL be 0 and rsp_err SHALL be 1.
REQ-021 In RESP, rsp_valid SHALL be 1 for one cycle, then the FSM SHALL return to IDLE unconditionally (no response back-pressure).
REQ-022 rsp_valid SHALL be high exactly WAIT_CYCLES+1 cycles after the accept edge; the earliest next accept is the cycle after RESP.
REQ-023 rdata and rsp_err SHALL hold their values until the next access edge; they are don't-care when rsp_valid=0.
REQ-024 A read following a write to the same word SHALL return the merged data (no stale read).
REQ-025 A req_valid asserted while not in IDLE SHALL NOT be accepted and SHALL NOT be lost; it is accepted once back in IDLE if still asserted.

Reset
REQ-026 While rst_n=0, the FSM SHALL be in IDLE with counter=0, req_ready=1, rsp_valid=0, rdata=0 and rsp_err=0.
REQ-027 Reset asserted in WAIT, before the access edge, SHALL abort the request with no memory write and no response.
REQ-028 Memory array contents SHALL NOT be reset; they are preserved across reset.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE/WAIT/RESP), the word width expression and the wr_mode read encoding constant.
REQ-030 One sub-module, dmem_bram, SHALL implement the DEPTH x 4 lane byte-enabled synchronous RAM: one port, write-first, registered read, no reset.

Verification
REQ-031 WAIT_CYCLES=1: write addr 5, wr_mode 1111, data 0xDEADBEEF -> rsp_valid 2 cycles after accept, rdata 0, rsp_err 0; then read addr 5 -> rdata 0xDEADBEEF.
REQ-032 Partial write: addr 5 wr_mode 0100, data 0x00AA0000 over 0xDEADBEEF -> read returns 0xDEAABEEF; wr_mode 1000, data 0x11000000 -> 0x11AABEEF.
REQ-033 Out of range: DEPTH=1024, write addr 1024 -> rsp_err 1, no write; read addr 1024 -> rdata 0, rsp_err 1; addr 1023 still intact.
REQ-034 Back-to-back: req_valid held high for 3 reads -> req_ready low in WAIT/RESP; exactly 3 rsp_valid pulses, WAIT_CYCLES+2 cycles apart.
REQ-035 Reset in WAIT: WAIT_CYCLES=3, write to addr 7, rst_n pulsed low in WAIT -> no rsp_valid; a read of addr 7 returns its old value; outputs match REQ-026 during reset.
REQ-036 WAIT_CYCLES=0: read -> rsp_valid the cycle after accept; one request every 2 cycles under continuous req_valid.
